// File: rtl/reservation_station.sv
// Reservation station for ALU-class ops: holds issued instructions until both operands are ready.
// Latency: one cycle from a front request to the registered dispatch on the alu_* outputs.
// Backpressure: rdy_in=0 freezes all state; the issue stage pushes only into slots reported free.
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int RS_W    = 4,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              rs_push,
    input  logic [RS_W-1:0]   rs_push_pos,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_pc,
    input  logic [DATA_W-1:0] issue_pred_pc,
    input  logic [ROB_W-1:0]  issue_robpos,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic              issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic              issue_qk,
    input  logic              rs_front,
    input  logic [RS_W-1:0]   rs_front_pos,
    input  logic              alu_cdb_flag,
    input  logic [ROB_W-1:0]  alu_cdb_robpos,
    input  logic [DATA_W-1:0] alu_cdb_val,
    input  logic              lsb_cdb_flag,
    input  logic [ROB_W-1:0]  lsb_cdb_robpos,
    input  logic [DATA_W-1:0] lsb_cdb_val,
    output logic              rs_avail,
    output logic [RS_W-1:0]   rs_avail_pos,
    output logic              rs_ready,
    output logic [RS_W-1:0]   rs_ready_pos,
    output logic              alu_flag,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_vj,
    output logic [DATA_W-1:0] alu_vk,
    output logic [DATA_W-1:0] alu_imm,
    output logic [DATA_W-1:0] alu_pc,
    output logic [DATA_W-1:0] alu_pred_pc,
    output logic [ROB_W-1:0]  alu_robpos
);

    logic [RS_SIZE-1:0]             busy_q, busy_d, qj_q, qj_d, qk_q, qk_d;
    logic [RS_SIZE-1:0][OP_W-1:0]   op_q, op_d;
    logic [RS_SIZE-1:0][DATA_W-1:0] imm_q, imm_d, pc_q, pc_d, pred_q, pred_d;
    logic [RS_SIZE-1:0][DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [RS_SIZE-1:0][ROB_W-1:0]  rob_q, rob_d;

    logic              alu_flag_q, alu_flag_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_vj_q, alu_vj_d, alu_vk_q, alu_vk_d;
    logic [DATA_W-1:0] alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d, alu_pred_q, alu_pred_d;
    logic [ROB_W-1:0]  alu_rob_q, alu_rob_d;

    // Lowest-index free slot and lowest-index ready slot (descending scan so the lowest wins).
    always_comb begin
        rs_avail     = 1'b0;
        rs_avail_pos = '0;
        rs_ready     = 1'b0;
        rs_ready_pos = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                rs_avail     = 1'b1;
                rs_avail_pos = RS_W'(i);
            end
            if (busy_q[i] && !qj_q[i] && !qk_q[i]) begin
                rs_ready     = 1'b1;
                rs_ready_pos = RS_W'(i);
            end
        end
    end

    // Next state: flush, else CDB snoop on held entries, dispatch, and push with same-cycle forwarding.
    always_comb begin
        busy_d = busy_q;  qj_d = qj_q;  qk_d = qk_q;
        op_d = op_q;  imm_d = imm_q;  pc_d = pc_q;  pred_d = pred_q;
        vj_d = vj_q;  vk_d = vk_q;  rob_d = rob_q;
        alu_flag_d = 1'b0;
        alu_op_d = alu_op_q;  alu_vj_d = alu_vj_q;  alu_vk_d = alu_vk_q;
        alu_imm_d = alu_imm_q;  alu_pc_d = alu_pc_q;  alu_pred_d = alu_pred_q;
        alu_rob_d = alu_rob_q;
        if (rob_clear) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                // ALU CDB is checked first so it wins when both buses carry the same tag.
                if (busy_q[i] && qj_q[i]) begin
                    if (alu_cdb_flag && alu_cdb_robpos == vj_q[i][ROB_W-1:0]) begin
                        vj_d[i] = alu_cdb_val;  qj_d[i] = 1'b0;
                    end else if (lsb_cdb_flag && lsb_cdb_robpos == vj_q[i][ROB_W-1:0]) begin
                        vj_d[i] = lsb_cdb_val;  qj_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_q[i]) begin
                    if (alu_cdb_flag && alu_cdb_robpos == vk_q[i][ROB_W-1:0]) begin
                        vk_d[i] = alu_cdb_val;  qk_d[i] = 1'b0;
                    end else if (lsb_cdb_flag && lsb_cdb_robpos == vk_q[i][ROB_W-1:0]) begin
                        vk_d[i] = lsb_cdb_val;  qk_d[i] = 1'b0;
                    end
                end
            end
            if (rs_front && busy_q[rs_front_pos] && !qj_q[rs_front_pos] && !qk_q[rs_front_pos]) begin
                alu_flag_d   = 1'b1;
                alu_op_d     = op_q[rs_front_pos];
                alu_vj_d     = vj_q[rs_front_pos];
                alu_vk_d     = vk_q[rs_front_pos];
                alu_imm_d    = imm_q[rs_front_pos];
                alu_pc_d     = pc_q[rs_front_pos];
                alu_pred_d   = pred_q[rs_front_pos];
                alu_rob_d    = rob_q[rs_front_pos];
                busy_d[rs_front_pos] = 1'b0;
            end
            // A slot freed by front this cycle still reads busy here, so a push to it is dropped.
            if (rs_push && !busy_q[rs_push_pos]) begin
                busy_d[rs_push_pos] = 1'b1;
                op_d[rs_push_pos]   = issue_op;
                imm_d[rs_push_pos]  = issue_imm;
                pc_d[rs_push_pos]   = issue_pc;
                pred_d[rs_push_pos] = issue_pred_pc;
                rob_d[rs_push_pos]  = issue_robpos;
                vj_d[rs_push_pos]   = issue_vj;
                qj_d[rs_push_pos]   = issue_qj;
                vk_d[rs_push_pos]   = issue_vk;
                qk_d[rs_push_pos]   = issue_qk;
                if (issue_qj) begin
                    if (alu_cdb_flag && alu_cdb_robpos == issue_vj[ROB_W-1:0]) begin
                        vj_d[rs_push_pos] = alu_cdb_val;  qj_d[rs_push_pos] = 1'b0;
                    end else if (lsb_cdb_flag && lsb_cdb_robpos == issue_vj[ROB_W-1:0]) begin
                        vj_d[rs_push_pos] = lsb_cdb_val;  qj_d[rs_push_pos] = 1'b0;
                    end
                end
                if (issue_qk) begin
                    if (alu_cdb_flag && alu_cdb_robpos == issue_vk[ROB_W-1:0]) begin
                        vk_d[rs_push_pos] = alu_cdb_val;  qk_d[rs_push_pos] = 1'b0;
                    end else if (lsb_cdb_flag && lsb_cdb_robpos == issue_vk[ROB_W-1:0]) begin
                        vk_d[rs_push_pos] = lsb_cdb_val;  qk_d[rs_push_pos] = 1'b0;
                    end
                end
            end
        end
    end

    // State register; rdy_in low holds everything, including alu_flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;  qj_q <= '0;  qk_q <= '0;
            op_q <= '0;  imm_q <= '0;  pc_q <= '0;  pred_q <= '0;
            vj_q <= '0;  vk_q <= '0;  rob_q <= '0;
            alu_flag_q <= 1'b0;  alu_op_q <= '0;  alu_vj_q <= '0;  alu_vk_q <= '0;
            alu_imm_q <= '0;  alu_pc_q <= '0;  alu_pred_q <= '0;  alu_rob_q <= '0;
        end else if (rdy_in) begin
            busy_q <= busy_d;  qj_q <= qj_d;  qk_q <= qk_d;
            op_q <= op_d;  imm_q <= imm_d;  pc_q <= pc_d;  pred_q <= pred_d;
            vj_q <= vj_d;  vk_q <= vk_d;  rob_q <= rob_d;
            alu_flag_q <= alu_flag_d;  alu_op_q <= alu_op_d;  alu_vj_q <= alu_vj_d;
            alu_vk_q <= alu_vk_d;  alu_imm_q <= alu_imm_d;  alu_pc_q <= alu_pc_d;
            alu_pred_q <= alu_pred_d;  alu_rob_q <= alu_rob_d;
        end
    end

    assign alu_flag    = alu_flag_q;
    assign alu_op      = alu_op_q;
    assign alu_vj      = alu_vj_q;
    assign alu_vk      = alu_vk_q;
    assign alu_imm     = alu_imm_q;
    assign alu_pc      = alu_pc_q;
    assign alu_pred_pc = alu_pred_q;
    assign alu_robpos  = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

    logic        clk_in = 1'b0, rst_in, rdy_in, rob_clear;
    logic        rs_push, rs_front, issue_qj, issue_qk;
    logic [3:0]  rs_push_pos, rs_front_pos, issue_robpos;
    logic [5:0]  issue_op;
    logic [31:0] issue_imm, issue_pc, issue_pred_pc, issue_vj, issue_vk;
    logic        alu_cdb_flag, lsb_cdb_flag;
    logic [3:0]  alu_cdb_robpos, lsb_cdb_robpos;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic        rs_avail, rs_ready, alu_flag;
    logic [3:0]  rs_avail_pos, rs_ready_pos, alu_robpos;
    logic [5:0]  alu_op;
    logic [31:0] alu_vj, alu_vk, alu_imm, alu_pc, alu_pred_pc;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc, pred;
        logic [3:0]  rob;
    } disp_t;

    disp_t exp_q[$];
    int total = 0;
    int bad = 0;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .rs_push(rs_push), .rs_push_pos(rs_push_pos), .issue_op(issue_op),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_pred_pc(issue_pred_pc),
        .issue_robpos(issue_robpos), .issue_vj(issue_vj), .issue_qj(issue_qj),
        .issue_vk(issue_vk), .issue_qk(issue_qk), .rs_front(rs_front),
        .rs_front_pos(rs_front_pos), .alu_cdb_flag(alu_cdb_flag),
        .alu_cdb_robpos(alu_cdb_robpos), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_flag(lsb_cdb_flag), .lsb_cdb_robpos(lsb_cdb_robpos),
        .lsb_cdb_val(lsb_cdb_val), .rs_avail(rs_avail), .rs_avail_pos(rs_avail_pos),
        .rs_ready(rs_ready), .rs_ready_pos(rs_ready_pos), .alu_flag(alu_flag),
        .alu_op(alu_op), .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_pred_pc(alu_pred_pc), .alu_robpos(alu_robpos)
    );

    always #5 clk_in = ~clk_in;

    // Expected dispatch record; the stimulus uses pc = imm + 0x8000 and pred = imm + 0x8004.
    function automatic disp_t mk(logic [5:0] op, logic [31:0] vj, logic [31:0] vk,
                                 logic [31:0] imm, logic [3:0] rob);
        disp_t d;
        d.op = op;  d.vj = vj;  d.vk = vk;  d.imm = imm;
        d.pc = imm + 32'h8000;  d.pred = imm + 32'h8004;  d.rob = rob;
        return d;
    endfunction

    // Monitor: every dispatch seen on the ALU port is matched against the scoreboard head.
    always @(negedge clk_in) begin
        if (!rst_in && alu_flag) begin
            disp_t act;
            act = {alu_op, alu_vj, alu_vk, alu_imm, alu_pc, alu_pred_pc, alu_robpos};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dispatch_unexpected act=%h required=none", act);
            end else begin
                disp_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL dispatch act=%h required=%h", act, e);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
        rs_push = 0;  rs_front = 0;  rob_clear = 0;
        alu_cdb_flag = 0;  lsb_cdb_flag = 0;
    endtask

    task automatic set_push(logic [3:0] pos, logic [5:0] op, logic [31:0] vj, logic qj,
                            logic [31:0] vk, logic qk, logic [3:0] rob, logic [31:0] imm);
        rs_push = 1;  rs_push_pos = pos;  issue_op = op;
        issue_vj = vj;  issue_qj = qj;  issue_vk = vk;  issue_qk = qk;
        issue_robpos = rob;  issue_imm = imm;
        issue_pc = imm + 32'h8000;  issue_pred_pc = imm + 32'h8004;
    endtask

    task automatic set_front(logic [3:0] pos);
        rs_front = 1;  rs_front_pos = pos;
    endtask

    initial begin
        rst_in = 1;  rdy_in = 1;  rob_clear = 0;
        rs_push = 0;  rs_push_pos = 0;  rs_front = 0;  rs_front_pos = 0;
        issue_op = 0;  issue_imm = 0;  issue_pc = 0;  issue_pred_pc = 0;
        issue_robpos = 0;  issue_vj = 0;  issue_qj = 0;  issue_vk = 0;  issue_qk = 0;
        alu_cdb_flag = 0;  alu_cdb_robpos = 0;  alu_cdb_val = 0;
        lsb_cdb_flag = 0;  lsb_cdb_robpos = 0;  lsb_cdb_val = 0;
        #12;
        chk("rst_avail", rs_avail, 1);
        chk("rst_avail_pos", rs_avail_pos, 0);
        chk("rst_ready", rs_ready, 0);
        chk("rst_alu_flag", alu_flag, 0);
        rst_in = 0;

        // Basic push then dispatch.
        set_push(0, 6'd1, 5, 0, 7, 0, 3, 32'h10);
        cyc();
        chk("push_ready", rs_ready, 1);
        chk("push_ready_pos", rs_ready_pos, 0);
        chk("push_avail_pos", rs_avail_pos, 1);
        exp_q.push_back(mk(6'd1, 5, 7, 32'h10, 3));
        set_front(0);
        cyc();
        chk("front_flag", alu_flag, 1);
        chk("front_avail_pos", rs_avail_pos, 0);
        cyc();
        chk("flag_drop", alu_flag, 0);

        // Pending operand woken by the ALU CDB.
        set_push(0, 6'd2, 9, 1, 2, 0, 5, 32'h20);
        cyc();
        chk("pend_not_ready", rs_ready, 0);
        alu_cdb_flag = 1;  alu_cdb_robpos = 9;  alu_cdb_val = 32'h1234;
        cyc();
        chk("snoop_ready", rs_ready, 1);
        // Push to a busy slot is ignored.
        set_push(0, 6'd9, 99, 0, 99, 0, 1, 32'h99);
        cyc();
        exp_q.push_back(mk(6'd2, 32'h1234, 2, 32'h20, 5));
        set_front(0);
        cyc();

        // Same-cycle forwarding from the load CDB.
        set_push(0, 6'd3, 1, 0, 4, 1, 6, 32'h30);
        lsb_cdb_flag = 1;  lsb_cdb_robpos = 4;  lsb_cdb_val = 32'hAB;
        cyc();
        chk("fwd_ready", rs_ready, 1);
        exp_q.push_back(mk(6'd3, 1, 32'hAB, 32'h30, 6));
        set_front(0);
        cyc();

        // Both CDBs carry the same tag: ALU value wins.
        set_push(1, 6'd4, 6, 1, 8, 0, 7, 32'h40);
        cyc();
        alu_cdb_flag = 1;  alu_cdb_robpos = 6;  alu_cdb_val = 32'hA;
        lsb_cdb_flag = 1;  lsb_cdb_robpos = 6;  lsb_cdb_val = 32'hB;
        cyc();
        chk("both_ready_pos", rs_ready_pos, 1);
        exp_q.push_back(mk(6'd4, 32'hA, 8, 32'h40, 7));
        set_front(1);
        cyc();

        // Front of a non-ready slot does nothing.
        set_push(2, 6'd5, 3, 1, 0, 0, 2, 32'h50);
        cyc();
        set_front(2);
        cyc();
        chk("nr_front_flag", alu_flag, 0);
        chk("nr_front_avail_pos", rs_avail_pos, 0);
        rob_clear = 1;
        cyc();
        chk("clr1_avail_pos", rs_avail_pos, 0);

        // rdy_in low freezes state.
        rdy_in = 0;
        set_push(0, 6'd6, 1, 0, 1, 0, 1, 32'h60);
        cyc();
        chk("frozen_avail_pos", rs_avail_pos, 0);
        chk("frozen_ready", rs_ready, 0);
        rdy_in = 1;

        // Fill all slots.
        for (int i = 0; i < 16; i++) begin
            set_push(4'(i), 6'd7, i, 0, i + 100, 0, 4'(i), 32'h200 + i);
            cyc();
        end
        chk("full_avail", rs_avail, 0);
        chk("full_avail_pos", rs_avail_pos, 0);
        exp_q.push_back(mk(6'd7, 5, 105, 32'h205, 5));
        set_front(5);
        cyc();
        chk("free5_avail", rs_avail, 1);
        chk("free5_avail_pos", rs_avail_pos, 5);
        // Push and front on different slots in one cycle.
        set_push(5, 6'd8, 55, 0, 56, 0, 9, 32'h300);
        exp_q.push_back(mk(6'd7, 6, 106, 32'h206, 6));
        set_front(6);
        cyc();
        chk("swap_avail_pos", rs_avail_pos, 6);

        // Flush beats push and front in the same cycle.
        rob_clear = 1;
        set_push(6, 6'd9, 1, 0, 1, 0, 1, 32'h400);
        set_front(7);
        cyc();
        chk("clr_avail_pos", rs_avail_pos, 0);
        chk("clr_ready", rs_ready, 0);
        chk("clr_alu_flag", alu_flag, 0);
        cyc();
        chk("clr_avail_pos2", rs_avail_pos, 0);

        // Asynchronous reset with three busy entries.
        for (int i = 0; i < 3; i++) begin
            set_push(4'(i), 6'd1, 1, 0, 1, 0, 1, 32'h500);
            cyc();
        end
        chk("pre_rst_avail_pos", rs_avail_pos, 3);
        #2 rst_in = 1;
        #1;
        chk("mid_rst_avail", rs_avail, 1);
        chk("mid_rst_avail_pos", rs_avail_pos, 0);
        chk("mid_rst_ready", rs_ready, 0);
        chk("mid_rst_alu_flag", alu_flag, 0);
        @(posedge clk_in);
        #1 rst_in = 0;
        cyc();

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
